// File: rtl/kmeans_pkg.sv
// Shared constants and divider state encoding for the k-means mean stage.
package kmeans_pkg;

  localparam int SUM_W  = 25;
  localparam int CNT_W  = 13;
  localparam int MEAN_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_core.sv
// Single-channel sequential restoring divider: one quotient bit per step, MSB first.
// dividend_hi seeds the remainder so a dividend one bit wider than N_W still needs N_W steps.
module div_core #(
  parameter int N_W = 25,
  parameter int D_W = 13
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic           step,
  input  logic [N_W-1:0] dividend,
  input  logic           dividend_hi,
  input  logic [D_W-1:0] divisor,
  output logic [N_W-1:0] quotient
);

  logic [N_W-1:0] quo_reg;
  logic [D_W-1:0] rem_reg;
  logic [D_W-1:0] div_reg;
  logic [D_W:0]   rem_shift;
  logic [D_W-1:0] rem_sub;

  // The true difference is always below the divisor, so D_W bits hold it exactly.
  always_comb begin
    rem_shift = {rem_reg, quo_reg[N_W-1]};
    rem_sub   = rem_shift[D_W-1:0] - div_reg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quo_reg <= '0;
      rem_reg <= '0;
      div_reg <= '0;
    end else if (load) begin
      quo_reg <= dividend;
      rem_reg <= {{(D_W-1){1'b0}}, dividend_hi};
      div_reg <= divisor;
    end else if (step) begin
      if (rem_shift >= {1'b0, div_reg}) begin
        rem_reg <= rem_sub;
        quo_reg <= {quo_reg[N_W-2:0], 1'b1};
      end else begin
        rem_reg <= rem_shift[D_W-1:0];
        quo_reg <= {quo_reg[N_W-2:0], 1'b0};
      end
    end
  end

  assign quotient = quo_reg;

endmodule

// File: rtl/cluster_mean_divider.sv
// Per-cluster RGB mean stage: divides three channel sums by the pixel count, saturating to MEAN_W bits.
// Define MEAN_DIV_ROUND_EN for round-to-nearest; the default build truncates.
module cluster_mean_divider #(
  parameter int SUM_W  = kmeans_pkg::SUM_W,
  parameter int CNT_W  = kmeans_pkg::CNT_W,
  parameter int MEAN_W = kmeans_pkg::MEAN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              enable,
  input  logic [SUM_W-1:0]  red_sum,
  input  logic [SUM_W-1:0]  green_sum,
  input  logic [SUM_W-1:0]  blue_sum,
  input  logic [CNT_W-1:0]  count,
  output logic              rgb_ready,
  output logic [MEAN_W-1:0] r_mean,
  output logic [MEAN_W-1:0] g_mean,
  output logic [MEAN_W-1:0] b_mean
);

  import kmeans_pkg::*;

  localparam int IT_W = $clog2(SUM_W + 1);

  div_state_t        state_reg, state_next;
  logic [IT_W-1:0]   iter_reg, iter_next;
  logic              ready_reg, ready_next;
  logic              load, step, finish;

  logic [SUM_W-1:0]  sum_arr [3];
  logic [SUM_W-1:0]  dvd_arr [3];
  logic [SUM_W-1:0]  quo_arr [3];
  logic [2:0]        hi_arr;
  logic [2:0][MEAN_W-1:0] mean_arr;

  assign sum_arr[0] = red_sum;
  assign sum_arr[1] = green_sum;
  assign sum_arr[2] = blue_sum;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      logic [MEAN_W-1:0] mean_reg;
      logic [MEAN_W-1:0] sat_val;

`ifdef MEAN_DIV_ROUND_EN
      // One extra bit keeps sum + floor(count/2) from wrapping.
      logic [SUM_W:0] rounded;
      assign rounded      = {1'b0, sum_arr[gi]} + (SUM_W+1)'(count >> 1);
      assign dvd_arr[gi]  = rounded[SUM_W-1:0];
      assign hi_arr[gi]   = rounded[SUM_W];
`else
      assign dvd_arr[gi]  = sum_arr[gi];
      assign hi_arr[gi]   = 1'b0;
`endif

      div_core #(
        .N_W(SUM_W),
        .D_W(CNT_W)
      ) u_div (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .step       (step),
        .dividend   (dvd_arr[gi]),
        .dividend_hi(hi_arr[gi]),
        .divisor    (count),
        .quotient   (quo_arr[gi])
      );

      assign sat_val = (|quo_arr[gi][SUM_W-1:MEAN_W]) ? '1 : quo_arr[gi][MEAN_W-1:0];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          mean_reg <= '0;
        end else if (finish) begin
          mean_reg <= sat_val;
        end
      end

      assign mean_arr[gi] = mean_reg;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    iter_next  = iter_reg;
    ready_next = ready_reg;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: begin
        ready_next = 1'b0;
        if (start) begin
          if (enable && (count != '0)) begin
            load       = 1'b1;
            iter_next  = '0;
            state_next = BUSY;
          end else begin
            state_next = DONE;
          end
        end
      end
      BUSY: begin
        if (!start) begin
          state_next = IDLE;
        end else if (iter_reg == IT_W'(SUM_W)) begin
          finish     = 1'b1;
          ready_next = 1'b1;
          state_next = DONE;
        end else begin
          step      = 1'b1;
          iter_next = iter_reg + 1'b1;
        end
      end
      DONE: begin
        // The empty/disabled path enters with ready low and raises it one edge later.
        if (start) begin
          ready_next = 1'b1;
        end else begin
          ready_next = 1'b0;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        ready_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      iter_reg  <= '0;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      iter_reg  <= iter_next;
      ready_reg <= ready_next;
    end
  end

  assign rgb_ready = ready_reg;
  assign r_mean    = mean_arr[0];
  assign g_mean    = mean_arr[1];
  assign b_mean    = mean_arr[2];

endmodule

// File: tb/tb_cluster_mean_divider.sv
// Self-checking bench for cluster_mean_divider: vector table, hand-written corner sequences, random ops.
module tb_cluster_mean_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        enable;
  logic [24:0] red_sum, green_sum, blue_sum;
  logic [12:0] count;
  logic        rgb_ready;
  logic [7:0]  r_mean, g_mean, b_mean;

  int checks   = 0;
  int failures = 0;
  int m_r = 0, m_g = 0, m_b = 0;

  always #5 clk = ~clk;

  cluster_mean_divider dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .enable   (enable),
    .red_sum  (red_sum),
    .green_sum(green_sum),
    .blue_sum (blue_sum),
    .count    (count),
    .rgb_ready(rgb_ready),
    .r_mean   (r_mean),
    .g_mean   (g_mean),
    .b_mean   (b_mean)
  );

  typedef struct {
    longint r, g, b, c;
    logic   en;
    int     er, eg, eb;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Mean as defined arithmetically: (optionally rounded) integer quotient clipped to 255.
  function automatic int ref_mean(input longint s, input longint c);
    longint q;
`ifdef MEAN_DIV_ROUND_EN
    q = (s + c / 2) / c;
`else
    q = s / c;
`endif
    return (q > 255) ? 255 : int'(q);
  endfunction

  task automatic run_op(input string tag, input longint r, input longint g, input longint b,
                        input longint c, input logic en, input int er, input int eg, input int eb);
    int exp_lat;
    int lat;
    exp_lat = (en && c != 0) ? 26 : 1;
    @(negedge clk);
    red_sum   = r[24:0];
    green_sum = g[24:0];
    blue_sum  = b[24:0];
    count     = c[12:0];
    enable    = en;
    start     = 1'b1;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 0) begin
        red_sum   = 25'($urandom);
        green_sum = 25'($urandom);
        blue_sum  = 25'($urandom);
        count     = 13'($urandom);
        enable    = 1'($urandom);
      end
      if (rgb_ready) begin
        lat = i;
        break;
      end
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " r_mean"}, r_mean, er);
    check({tag, " g_mean"}, g_mean, eg);
    check({tag, " b_mean"}, b_mean, eb);
    repeat (3) @(negedge clk);
    check({tag, " ready held"}, rgb_ready, 1);
    check({tag, " r held"}, r_mean, er);
    start = 1'b0;
    @(negedge clk);
    check({tag, " ready drop"}, rgb_ready, 0);
    check({tag, " b after drop"}, b_mean, eb);
    m_r = er;
    m_g = eg;
    m_b = eb;
    $display("op %s sums=%0d/%0d/%0d count=%0d en=%0d -> lat=%0d means=%0d/%0d/%0d",
             tag, r, g, b, c, en, lat, r_mean, g_mean, b_mean);
  endtask

  task automatic run_model_op(input string tag, input longint r, input longint g, input longint b,
                              input longint c, input logic en);
    if (en && c != 0)
      run_op(tag, r, g, b, c, en, ref_mean(r, c), ref_mean(g, c), ref_mean(b, c));
    else
      run_op(tag, r, g, b, c, en, m_r, m_g, m_b);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    int   seen;
    tbl[0] = '{2550, 1000, 0, 10, 1'b1, 255, 100, 0};
`ifdef MEAN_DIV_ROUND_EN
    tbl[1] = '{19, 15, 5, 10, 1'b1, 2, 2, 1};
`else
    tbl[1] = '{19, 15, 5, 10, 1'b1, 1, 1, 0};
`endif
    tbl[2] = '{3000, 50, 90, 10, 1'b1, 255, 5, 9};
    tbl[3] = '{33554431, 1638200, 0, 8191, 1'b1, 255, 200, 0};
    tbl[4] = '{255, 256, 1, 1, 1'b1, 255, 255, 1};
    tbl[5] = '{100, 200, 300, 10, 1'b1, 10, 20, 30};
    tbl[6] = '{7, 8, 9, 0, 1'b1, 10, 20, 30};
    tbl[7] = '{7, 8, 9, 4, 1'b0, 10, 20, 30};

    reset = 1'b1;
    start = 1'b0;
    enable = 1'b0;
    red_sum = '0;
    green_sum = '0;
    blue_sum = '0;
    count = '0;
    repeat (2) @(negedge clk);
    check("reset ready", rgb_ready, 0);
    check("reset r_mean", r_mean, 0);
    check("reset g_mean", g_mean, 0);
    check("reset b_mean", b_mean, 0);
    reset = 1'b0;

    for (int v = 0; v < 8; v++)
      run_op($sformatf("vec%0d", v), tbl[v].r, tbl[v].g, tbl[v].b, tbl[v].c, tbl[v].en,
             tbl[v].er, tbl[v].eg, tbl[v].eb);

    // Reset mid-BUSY must clear outputs without a clock edge.
    @(negedge clk);
    red_sum = 25'd500; green_sum = 25'd500; blue_sum = 25'd500; count = 13'd5;
    enable = 1'b1; start = 1'b1;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midbusy reset ready", rgb_ready, 0);
    check("midbusy reset r_mean", r_mean, 0);
    check("midbusy reset g_mean", g_mean, 0);
    check("midbusy reset b_mean", b_mean, 0);
    $display("op reset mid-busy -> ready=%0d means=%0d/%0d/%0d", rgb_ready, r_mean, g_mean, b_mean);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    m_r = 0; m_g = 0; m_b = 0;
    run_op("post_reset", 100, 200, 300, 10, 1'b1, 10, 20, 30);

    // Abort: start sampled low at C+10 leaves ready low and means untouched.
    @(negedge clk);
    red_sum = 25'd2550; green_sum = 25'd2550; blue_sum = 25'd2550; count = 13'd10;
    enable = 1'b1; start = 1'b1;
    repeat (10) @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rgb_ready) seen++;
    end
    check("abort ready never", seen, 0);
    check("abort r_mean", r_mean, 10);
    check("abort g_mean", g_mean, 20);
    check("abort b_mean", b_mean, 30);
    $display("op abort -> ready_seen=%0d means=%0d/%0d/%0d", seen, r_mean, g_mean, b_mean);
    run_op("restart", 500, 500, 500, 5, 1'b1, 100, 100, 100);

    for (int n = 0; n < 40; n++) begin
      longint c, r, g, b;
      logic   en;
      c  = (n % 4 == 0) ? longint'($urandom_range(0, 3)) : longint'($urandom_range(1, 8191));
      en = ($urandom_range(0, 7) != 0);
      if (n % 3 == 0) begin
        r = longint'($urandom_range(0, 33554431));
        g = longint'($urandom_range(0, 33554431));
        b = longint'($urandom_range(0, 33554431));
      end else begin
        r = c * longint'($urandom_range(0, 300)) + longint'($urandom_range(0, 8191)) % (c + 1);
        g = c * longint'($urandom_range(0, 300)) + longint'($urandom_range(0, 8191)) % (c + 1);
        b = c * longint'($urandom_range(0, 300)) + longint'($urandom_range(0, 8191)) % (c + 1);
      end
      run_model_op($sformatf("rnd%0d", n), r, g, b, c, en);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
